seven_seg_scan_mux: RTL and testbench

//   Downstream display stage of the top level: takes a 32-bit value from the datapath and time-multiplexes it as 8 hex digits.

---
 rtl/seg_pkg.sv | 48 ++++
 rtl/seven_seg_scan_mux_if.sv | 32 +++
 rtl/hex_to_7seg.sv | 13 +
 rtl/seven_seg_scan_mux.sv | 123 ++++++++++++
 tb/tb_seven_seg_scan_mux.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/seg_pkg.sv
// seg_pkg: shared constants for the seven-segment scan display.
//   NUM_DIGITS     number of scanned digits
//   IDX_W          width of a digit index
//   SEG_OFF        all segments dark (active-low)
//   ANODE_OFF      all anodes disabled (active-low)
//   HEX_SEG_TABLE  hex nibble -> {g,f,e,d,c,b,a}, active-low
//   msd_index()    index of the most-significant non-zero nibble (0 when the value is 0)
package seg_pkg;

  localparam int unsigned NUM_DIGITS = 8;
  localparam int unsigned IDX_W      = $clog2(NUM_DIGITS);

  localparam logic [6:0] SEG_OFF   = 7'h7F;
  localparam logic [7:0] ANODE_OFF = 8'hFF;

  // Entry n sits at HEX_SEG_TABLE[n]; the concatenation lists entry 15 first.
  localparam logic [15:0][6:0] HEX_SEG_TABLE = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  // Digit 0 is always reported, so an all-zero value still shows a single "0".
  function automatic logic [IDX_W-1:0] msd_index(input logic [4*NUM_DIGITS-1:0] value);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (value[4*i +: 4] != 4'h0) begin
        idx = IDX_W'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/seven_seg_scan_mux_if.sv
// seven_seg_scan_mux_if: value-load and display-drive bundle of the scan mux.
//   Load        capture Value_in this cycle
//   Value_in    32-bit value, nibble k -> digit k (digit 0 rightmost)
//   out7        segments {g,f,e,d,c,b,a}, active-low
//   en_out      digit anodes, active-low one-hot
//   Frame_done  1-cycle pulse when a new value is applied at a frame boundary
// master: the side supplying values (datapath / bench); slave: the scan mux.
interface seven_seg_scan_mux_if;

  logic        Load;
  logic [31:0] Value_in;
  logic [6:0]  out7;
  logic [7:0]  en_out;
  logic        Frame_done;

  modport master (
    output Load,
    output Value_in,
    input  out7,
    input  en_out,
    input  Frame_done
  );

  modport slave (
    input  Load,
    input  Value_in,
    output out7,
    output en_out,
    output Frame_done
  );

endinterface

// File: rtl/hex_to_7seg.sv
// hex_to_7seg: combinational hex nibble to active-low seven-segment decoder.
//   nibble  in   4  hex digit 0..F
//   seg     out  7  {g,f,e,d,c,b,a}, active-low
module hex_to_7seg
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = HEX_SEG_TABLE[nibble];

endmodule

// File: rtl/seven_seg_scan_mux.sv
// seven_seg_scan_mux: time-multiplexes a 32-bit value onto an 8-digit seven-segment display.
// A loaded value waits in a pending buffer and is copied to the displayed shadow only at a
// frame boundary (end of digit 7), so a frame never mixes two values.
//   Clk         in   system clock, rising edge
//   Rst         in   asynchronous active-low reset
//   bus         slave side of seven_seg_scan_mux_if (Load, Value_in, out7, en_out, Frame_done)
// Parameters:
//   REFRESH_DIV  clock cycles each digit stays lit (>= 1)
//   CNT_W        prescaler width, 2**CNT_W > REFRESH_DIV-1
// Build option:
//   LEADING_ZERO_BLANK_EN  when defined, digits above the most-significant non-zero nibble
//                          are blanked; digit 0 always shows. Undefined: all digits decode.
module seven_seg_scan_mux
  import seg_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned CNT_W       = 17
) (
  input  logic                 Clk,
  input  logic                 Rst,
  seven_seg_scan_mux_if.slave  bus
);

  localparam logic [CNT_W-1:0] TICK_VAL = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0] prescaler_q, prescaler_d;
  logic [IDX_W-1:0] digit_idx_q, digit_idx_d;
  logic [31:0]      shadow_q, shadow_d;
  logic [31:0]      pending_q, pending_d;
  logic             pend_v_q, pend_v_d;
  logic [6:0]       out7_q, out7_d;
  logic [7:0]       en_out_q, en_out_d;
  logic             frame_done_q, frame_done_d;

  logic             tick;
  logic             boundary;
  logic [3:0]       cur_nibble;
  logic [6:0]       cur_seg;
  logic             blank;

  assign tick     = (prescaler_q == TICK_VAL);
  assign boundary = tick && (digit_idx_q == LAST_IDX);

  // Prescaler and digit counter.
  always_comb begin
    prescaler_d = prescaler_q + CNT_W'(1);
    digit_idx_d = digit_idx_q;
    if (tick) begin
      prescaler_d = '0;
      digit_idx_d = digit_idx_q + IDX_W'(1);
    end
  end

  // Double buffer: a Load on the boundary cycle goes straight to the shadow and supersedes
  // any older pending value; otherwise Loads collect in pending (last one wins).
  always_comb begin
    shadow_d     = shadow_q;
    pending_d    = pending_q;
    pend_v_d     = pend_v_q;
    frame_done_d = 1'b0;
    if (boundary) begin
      if (bus.Load) begin
        shadow_d     = bus.Value_in;
        pend_v_d     = 1'b0;
        frame_done_d = 1'b1;
      end else if (pend_v_q) begin
        shadow_d     = pending_q;
        pend_v_d     = 1'b0;
        frame_done_d = 1'b1;
      end
    end else if (bus.Load) begin
      pending_d = bus.Value_in;
      pend_v_d  = 1'b1;
    end
  end

  assign cur_nibble = shadow_q[{digit_idx_q, 2'b00} +: 4];

  hex_to_7seg u_hex_to_7seg (
    .nibble (cur_nibble),
    .seg    (cur_seg)
  );

`ifdef LEADING_ZERO_BLANK_EN
  assign blank = (digit_idx_q > msd_index(shadow_q));
`else
  assign blank = 1'b0;
`endif

  // Outputs follow the current digit/shadow with one cycle of latency.
  always_comb begin
    en_out_d = ~(8'b1 << digit_idx_q);
    out7_d   = blank ? SEG_OFF : cur_seg;
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      prescaler_q  <= '0;
      digit_idx_q  <= '0;
      shadow_q     <= '0;
      pending_q    <= '0;
      pend_v_q     <= 1'b0;
      out7_q       <= SEG_OFF;
      en_out_q     <= ANODE_OFF;
      frame_done_q <= 1'b0;
    end else begin
      prescaler_q  <= prescaler_d;
      digit_idx_q  <= digit_idx_d;
      shadow_q     <= shadow_d;
      pending_q    <= pending_d;
      pend_v_q     <= pend_v_d;
      out7_q       <= out7_d;
      en_out_q     <= en_out_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.out7       = out7_q;
  assign bus.en_out     = en_out_q;
  assign bus.Frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_seg_scan_mux.sv
// tb_seven_seg_scan_mux: directed bench for seven_seg_scan_mux with REFRESH_DIV=4.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_seven_seg_scan_mux;

  logic Clk;
  logic Rst;
  int   tests_run;
  int   tests_failed;

  seven_seg_scan_mux_if bus ();

  seven_seg_scan_mux #(
    .REFRESH_DIV (4),
    .CNT_W       (2)
  ) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Active-low segment patterns written out from the decode table.
  function automatic logic [6:0] seg_of(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  function automatic logic [7:0] anode_of(input int k);
    logic [7:0] one;
    one = 8'b1;
    return ~(one << k);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_frame(input int budget, input string tag);
    int n;
    n = 0;
    while (bus.Frame_done !== 1'b1 && n < budget) begin
      @(negedge Clk);
      n++;
    end
    check(tag, 32'(bus.Frame_done), 32'd1);
  endtask

  task automatic wait_en(input logic [7:0] target, input int budget, input string tag);
    int n;
    n = 0;
    while (bus.en_out !== target && n < budget) begin
      @(negedge Clk);
      n++;
    end
    check(tag, 32'(bus.en_out), 32'(target));
  endtask

  initial begin
    logic [31:0] v;
    int          pulses;
    int          k;
    logic [6:0]  exp_seg;

    tests_run    = 0;
    tests_failed = 0;
    Rst          = 1'b0;
    bus.Load     = 1'b0;
    bus.Value_in = '0;

    // Reset state.
    repeat (2) @(negedge Clk);
    check("reset_out7", 32'(bus.out7), 32'h7F);
    check("reset_en", 32'(bus.en_out), 32'hFF);
    check("reset_fd", 32'(bus.Frame_done), 32'd0);
    Rst = 1'b1;
    @(negedge Clk);
    check("post_reset_out7", 32'(bus.out7), 32'h40);
    check("post_reset_en", 32'(bus.en_out), 32'hFE);

    // Full scan of 0123_4567: 4 samples per digit, digit k shows nibble k.
    v            = 32'h0123_4567;
    bus.Load     = 1'b1;
    bus.Value_in = v;
    @(negedge Clk);
    bus.Load = 1'b0;
    wait_frame(40, "scan_frame_done");
    for (int s = 0; s < 32; s++) begin
      @(negedge Clk);
      k = s / 4;
      check("scan_en", 32'(bus.en_out), 32'(anode_of(k)));
      check("scan_out7", 32'(bus.out7), 32'(seg_of(v[4*k +: 4])));
      check("scan_fd", 32'(bus.Frame_done), 32'd0);
    end
    @(negedge Clk);
    check("scan_wrap_en", 32'(bus.en_out), 32'hFE);
    check("scan_wrap_out7", 32'(bus.out7), 32'h78);

    // Tear-free: load at digit 3, digits 3..7 keep the old value.
    wait_en(8'hF7, 40, "tear_reach_digit3");
    bus.Load     = 1'b1;
    bus.Value_in = 32'hAAAA_AAAA;
    for (int s = 1; s < 20; s++) begin
      @(negedge Clk);
      bus.Load = 1'b0;
      k = 3 + s / 4;
      check("tear_old_en", 32'(bus.en_out), 32'(anode_of(k)));
      check("tear_old_out7", 32'(bus.out7), 32'(seg_of(v[4*k +: 4])));
      check("tear_fd", 32'(bus.Frame_done), (s == 19) ? 32'd1 : 32'd0);
    end
    for (int s = 0; s < 32; s++) begin
      @(negedge Clk);
      check("tear_new_en", 32'(bus.en_out), 32'(anode_of(s / 4)));
      check("tear_new_out7", 32'(bus.out7), 32'h08);
    end

    // Collision: 1111_1111 pending, 2222_2222 on the boundary cycle wins.
    pulses = 0;
    for (int s = 0; s < 32; s++) begin
      @(negedge Clk);
      check("coll_hold_out7", 32'(bus.out7), 32'h08);
      if (bus.Frame_done === 1'b1) pulses++;
      bus.Load = 1'b0;
      if (s == 4) begin
        bus.Load     = 1'b1;
        bus.Value_in = 32'h1111_1111;
      end else if (s == 30) begin
        bus.Load     = 1'b1;
        bus.Value_in = 32'h2222_2222;
      end
    end
    bus.Load = 1'b0;
    for (int s = 0; s < 32; s++) begin
      @(negedge Clk);
      check("coll_out7", 32'(bus.out7), 32'h24);
      if (bus.Frame_done === 1'b1) pulses++;
    end
    check("coll_pulses", 32'(pulses), 32'd1);

    // Idle boundaries: three frames with no Load.
    pulses = 0;
    for (int s = 0; s < 96; s++) begin
      @(negedge Clk);
      check("idle_en", 32'(bus.en_out), 32'(anode_of((s / 4) % 8)));
      check("idle_out7", 32'(bus.out7), 32'h24);
      if (bus.Frame_done === 1'b1) pulses++;
    end
    check("idle_pulses", 32'(pulses), 32'd0);

    // Leading-zero handling of 0000_00F0.
    bus.Load     = 1'b1;
    bus.Value_in = 32'h0000_00F0;
    @(negedge Clk);
    bus.Load = 1'b0;
    wait_frame(40, "lz_frame_done");
    for (int s = 0; s < 32; s++) begin
      @(negedge Clk);
      k = s / 4;
      if (k == 0) exp_seg = 7'b1000000;
      else if (k == 1) exp_seg = 7'b0001110;
`ifdef LEADING_ZERO_BLANK_EN
      else exp_seg = 7'h7F;
`else
      else exp_seg = 7'b1000000;
`endif
      check("lz_en", 32'(bus.en_out), 32'(anode_of(k)));
      check("lz_out7", 32'(bus.out7), 32'(exp_seg));
    end

    // Mid-scan reset at digit 5 discards a pending value.
    bus.Load     = 1'b1;
    bus.Value_in = 32'h3333_3333;
    @(negedge Clk);
    bus.Load = 1'b0;
    wait_en(8'hDF, 40, "rst_reach_digit5");
    #2;
    Rst = 1'b0;
    #1;
    check("midrst_out7", 32'(bus.out7), 32'h7F);
    check("midrst_en", 32'(bus.en_out), 32'hFF);
    check("midrst_fd", 32'(bus.Frame_done), 32'd0);
    @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    check("midrst_rel_out7", 32'(bus.out7), 32'h40);
    check("midrst_rel_en", 32'(bus.en_out), 32'hFE);
    pulses = 0;
    for (int s = 0; s < 40; s++) begin
      @(negedge Clk);
      check("midrst_out7_zero", 32'(bus.out7), 32'h40);
      if (bus.Frame_done === 1'b1) pulses++;
    end
    check("midrst_pulses", 32'(pulses), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
